board_io_adapter: RTL and testbench
===================================

Name: board_io_adapter

Overview:
Parametrised FPGA-board adapter between physical board I/O and the tt_um_* user design. It synchronises and debounces NUM_BTN push-buttons, producing clean levels plus press/release pulses. It generates a synchronised reset for the design. It registers the design's VGA colour/sync outputs and expands COLOR_IN_W-bit colour codes to the board DAC width, so a single top file serves any board/button/DAC combination.

Parameters:
NUM_BTN, 4, number of button channels
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required before a level change (>=1)
COLOR_IN_W, 2, per-channel colour width from the design
COLOR_OUT_W, 4, per-channel DAC width (>= COLOR_IN_W)
SYNC_IDLE, 1, reset value of hsync_out/vsync_out
REPEAT_DELAY, 50000000, cycles from press to first auto-repeat (used only with BOARD_IO_AUTOREPEAT_EN)
REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses (used only with BOARD_IO_AUTOREPEAT_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
btn_raw  in  NUM_BTN  raw asynchronous buttons, active-high
btn_level  out  NUM_BTN  debounced button level
btn_press  out  NUM_BTN  one-cycle pulse on debounced 0->1 (plus repeats, see Optional Feature)
btn_release  out  NUM_BTN  one-cycle pulse on debounced 1->0
rst_n_out  out  1  synchronised active-low reset for the user design
red_in/green_in/blue_in  in  COLOR_IN_W each  design colour codes
hsync_in/vsync_in  in  1  design sync outputs
red_out/green_out/blue_out  out  COLOR_OUT_W each  expanded, registered DAC values
hsync_out/vsync_out  out  1  registered syncs
led_in  in  8  design LED drive
led_out  out  8  registered LED drive

Behaviour:
- One clock, and reset is asynchronous, active-high.
- Reset values: btn_level, btn_press, btn_release, all sync flops, counters, colour outputs and led_out = 0. hsync_out = vsync_out = SYNC_IDLE. rst_n_out = 0.
- Reset synchroniser: rst_n_out asserts (0) asynchronously with reset. It deasserts on the 2nd rising edge after reset falls, via a 2-flop chain loaded with 1.
- Per button: a 2-flop synchroniser (s1, s2), then the debouncer.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - s2 == btn_level: counter <= 0.
  - s2 != btn_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level toggles, counter <= 0, and the matching press/release pulse is high for exactly the next cycle.
- Latency: a clean raw edge first sampled at edge 0 changes btn_level at edge DEBOUNCE_CYCLES+1.
- Glitch rejection: any bounce back to the old value before count completion resets the counter, so there is no level change and no pulse.
- btn_press and btn_release are never both high on one channel. Channels are fully independent, and simultaneous presses produce simultaneous pulses.
- Colour expansion per channel, for code c:
  - c == 0 gives 0.
  - c == all-ones gives all-ones (COLOR_OUT_W bits).
  - Otherwise c << (COLOR_OUT_W-COLOR_IN_W), zero-filled.
  - Defaults map 00->0000, 01->0100, 10->1000, 11->1111.
  - COLOR_OUT_W == COLOR_IN_W is identity.
- VGA/LED path is a one-register pipeline: colour, sync and LED outputs all lag inputs by exactly 1 cycle, so colour stays aligned to sync.
- Reset mid-operation returns all state to reset values immediately (asynchronously). No pulse is emitted on reset entry or exit.

Optional Feature:
BOARD_IO_AUTOREPEAT_EN
- Defined:
  - While btn_level stays 1, a per-channel repeat counter runs from the press edge.
  - An extra btn_press pulse fires REPEAT_DELAY cycles after the original pulse, then every REPEAT_PERIOD cycles.
  - The counter clears on release or reset.
  - btn_release is unaffected.
- Undefined: exactly one btn_press per debounced press. No repeat logic is synthesised, and REPEAT_* are ignored.

Decomposition:
- Package board_io_pkg:
  - Default width constants (COLOR_IN_W_DEF=2, COLOR_OUT_W_DEF=4).
  - Function expand_color(code) parametrised via widths.
  - Typedef for the debouncer counter.
- Sub-module btn_debounce: one channel of sync, debounce, pulse and optional repeat. Instantiated NUM_BTN times in a generate loop.
- Top keeps the reset synchroniser and VGA/LED register stage.

Test Plan:
- Reset held 5 cycles then released -> all outputs at reset values; rst_n_out goes 1 on the 2nd edge after release.
- DEBOUNCE_CYCLES=4, btn_raw[0] clean 0->1 -> btn_level[0]=1 at edge 5 after sampling; btn_press[0] high exactly 1 cycle; btn_release stays 0.
- DEBOUNCE_CYCLES=4, btn_raw[1] pulses high for 3 cycles -> no level change, no pulses.
- Buttons 0 and 3 pressed on the same cycle, then released -> press pulses coincide, release pulses coincide; channels 1 and 2 stay idle.
- red_in sweeps 0..3 with defaults -> red_out 0000, 0100, 1000, 1111 one cycle later; hsync_out/vsync_out delayed equally.
- With BOARD_IO_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, button held 20 cycles -> press pulses at t, t+8, t+11, t+14, t+17; none after release.

Source files
------------

// File: rtl/board_io_pkg.sv
// ----------------------------------------------------------------------------
// board_io_pkg
// Shared constants, types and helpers for the board I/O adapter.
//   COLOR_IN_W_DEF / COLOR_OUT_W_DEF : default colour widths (design / DAC)
//   DEBOUNCE_CYCLES_DEF               : default debounce length
//   db_cnt_def_t                      : debounce counter sized for the default
//   expand_color()                    : colour code to DAC value expansion
// ----------------------------------------------------------------------------
package board_io_pkg;

   localparam int COLOR_IN_W_DEF      = 2;
   localparam int COLOR_OUT_W_DEF     = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 250000;

   typedef logic [$clog2(DEBOUNCE_CYCLES_DEF+1)-1:0] db_cnt_def_t;

   // Black stays black and full scale stays full scale; every other code is
   // left-aligned into the wider DAC word with zero fill. Widths up to 32.
   function automatic logic [31:0] expand_color(input logic [31:0] code,
                                                input int inW,
                                                input int outW);
      logic [31:0] inOnes;
      logic [31:0] outOnes;
      inOnes  = ~(32'hFFFF_FFFF << inW);
      outOnes = ~(32'hFFFF_FFFF << outW);
      if (code == 32'd0) begin
         expand_color = 32'd0;
      end else if (code == inOnes) begin
         expand_color = outOnes;
      end else begin
         expand_color = code << (outW - inW);
      end
   endfunction

endpackage

// File: rtl/board_io_adapter_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// One button channel: 2-flop synchroniser, debouncer, press/release pulses
// and, when BOARD_IO_AUTOREPEAT_EN is defined, auto-repeat press pulses.
//   clock, reset    : system clock, asynchronous active-high reset
//   btn_raw         : raw asynchronous button input
//   btn_level       : debounced level
//   btn_press       : one-cycle pulse on debounced rise (and on repeats)
//   btn_release     : one-cycle pulse on debounced fall
// ----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES+1);

   logic             r_s1;
   logic             r_s2;
   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differ;
   logic             w_toggle;
   logic             w_repeat;

   assign w_differ = (r_s2 != r_level);
   assign w_toggle = w_differ && (r_cnt == CNT_W'(DEBOUNCE_CYCLES-1));

`ifdef BOARD_IO_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX+1);

   logic [RPT_W-1:0] r_rptCnt;
   logic             r_rptPeriodic;
   logic [RPT_W-1:0] w_rptTarget;

   // The first repeat waits the long delay, later ones the shorter period.
   // A debounced edge on the same cycle wins, so press and release never
   // coincide and no stray press follows the release.
   assign w_rptTarget = r_rptPeriodic ? RPT_W'(REPEAT_PERIOD-1) : RPT_W'(REPEAT_DELAY-1);
   assign w_repeat    = r_level && !w_toggle && (r_rptCnt == w_rptTarget);

   // Repeat timer is held clear while released and restarts on each press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rptCnt      <= '0;
         r_rptPeriodic <= 1'b0;
      end else if (!r_level || w_toggle) begin
         r_rptCnt      <= '0;
         r_rptPeriodic <= 1'b0;
      end else if (w_repeat) begin
         r_rptCnt      <= '0;
         r_rptPeriodic <= 1'b1;
      end else begin
         r_rptCnt      <= r_rptCnt + 1'b1;
      end
   end
`else
   assign w_repeat = 1'b0;
`endif

   // Synchronise, then require DEBOUNCE_CYCLES consecutive disagreeing
   // samples before the level flips; any agreement restarts the count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_level   <= 1'b0;
         r_cnt     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_s1      <= btn_raw;
         r_s2      <= r_s1;
         r_press   <= (w_toggle && !r_level) || w_repeat;
         r_release <= w_toggle && r_level;
         if (!w_differ || w_toggle) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_toggle) begin
            r_level <= !r_level;
         end
      end
   end

   assign btn_level   = r_level;
   assign btn_press   = r_press;
   assign btn_release = r_release;

endmodule

// File: rtl/board_io_adapter.sv
// ----------------------------------------------------------------------------
// board_io_adapter
// Adapter between physical board I/O and a tt_um_* user design.
//   clock, reset           : system clock, asynchronous active-high reset
//   btn_raw                : raw buttons -> btn_level/btn_press/btn_release
//   rst_n_out              : synchronised active-low reset for the design
//   red/green/blue_in      : design colour codes -> expanded, registered *_out
//   hsync_in/vsync_in      : design syncs -> registered hsync_out/vsync_out
//   led_in                 : design LEDs -> registered led_out
// Build option: define BOARD_IO_AUTOREPEAT_EN to add held-button auto-repeat.
// ----------------------------------------------------------------------------
module board_io_adapter
   import board_io_pkg::*;
#(
   parameter int   NUM_BTN         = 4,
   parameter int   DEBOUNCE_CYCLES = 250000,
   parameter int   COLOR_IN_W      = COLOR_IN_W_DEF,
   parameter int   COLOR_OUT_W     = COLOR_OUT_W_DEF,
   parameter logic SYNC_IDLE       = 1'b1,
   parameter int   REPEAT_DELAY    = 50000000,
   parameter int   REPEAT_PERIOD   = 10000000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NUM_BTN-1:0]     btn_raw,
   output logic [NUM_BTN-1:0]     btn_level,
   output logic [NUM_BTN-1:0]     btn_press,
   output logic [NUM_BTN-1:0]     btn_release,
   output logic                   rst_n_out,
   input  logic [COLOR_IN_W-1:0]  red_in,
   input  logic [COLOR_IN_W-1:0]  green_in,
   input  logic [COLOR_IN_W-1:0]  blue_in,
   input  logic                   hsync_in,
   input  logic                   vsync_in,
   output logic [COLOR_OUT_W-1:0] red_out,
   output logic [COLOR_OUT_W-1:0] green_out,
   output logic [COLOR_OUT_W-1:0] blue_out,
   output logic                   hsync_out,
   output logic                   vsync_out,
   input  logic [7:0]             led_in,
   output logic [7:0]             led_out
);

   logic [1:0] r_rstSync;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_btn (
         .clock       (clock),
         .reset       (reset),
         .btn_raw     (btn_raw[g]),
         .btn_level   (btn_level[g]),
         .btn_press   (btn_press[g]),
         .btn_release (btn_release[g])
      );
   end

   // Assert immediately with reset, release two clean edges after it drops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rstSync <= 2'b00;
      end else begin
         r_rstSync <= {r_rstSync[0], 1'b1};
      end
   end

   assign rst_n_out = r_rstSync[1];

   // Single register stage for colour, sync and LEDs keeps them aligned.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
         hsync_out <= SYNC_IDLE;
         vsync_out <= SYNC_IDLE;
         led_out   <= '0;
      end else begin
         red_out   <= COLOR_OUT_W'(expand_color(32'(red_in),   COLOR_IN_W, COLOR_OUT_W));
         green_out <= COLOR_OUT_W'(expand_color(32'(green_in), COLOR_IN_W, COLOR_OUT_W));
         blue_out  <= COLOR_OUT_W'(expand_color(32'(blue_in),  COLOR_IN_W, COLOR_OUT_W));
         hsync_out <= hsync_in;
         vsync_out <= vsync_in;
         led_out   <= led_in;
      end
   end

endmodule

// File: tb/tb_board_io_adapter.sv
module tb_board_io_adapter;

   localparam int NB  = 4;
   localparam int DC  = 4;
   localparam int CIW = 2;
   localparam int COW = 4;
   localparam int RD  = 8;
   localparam int RP  = 3;

   logic           clock = 1'b0;
   logic           reset;
   logic [NB-1:0]  btn_raw;
   logic [NB-1:0]  btn_level;
   logic [NB-1:0]  btn_press;
   logic [NB-1:0]  btn_release;
   logic           rst_n_out;
   logic [CIW-1:0] red_in, green_in, blue_in;
   logic           hsync_in, vsync_in;
   logic [COW-1:0] red_out, green_out, blue_out;
   logic           hsync_out, vsync_out;
   logic [7:0]     led_in, led_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NB-1:0] level;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
   } btnExp_t;

   typedef struct {
      logic [1:0] r, g, b;
      logic       hs, vs;
      logic [7:0] led;
      logic [3:0] er, eg, eb;
   } vgaVec_t;

   btnExp_t btnQ[$];
   logic [21:0] vgaQ[$];
   vgaVec_t vgaTab[6];

   board_io_adapter #(
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .COLOR_IN_W(CIW), .COLOR_OUT_W(COW),
      .SYNC_IDLE(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .rst_n_out(rst_n_out),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .led_in(led_in), .led_out(led_out)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Called at a negedge: drives rawFirst, switches to rawSecond once the
   // edge numbered switchAt is next, and compares one queued record per cycle.
   task automatic applyStimulus(input string name, input logic [NB-1:0] rawFirst,
                                input logic [NB-1:0] rawSecond, input int switchAt);
      btnExp_t e;
      int k;
      k = 0;
      btn_raw = rawFirst;
      while (btnQ.size() > 0) begin
         @(negedge clock);
         e = btnQ.pop_front();
         checkOutput($sformatf("%s k=%0d", name, k),
                     {52'd0, btn_level, btn_press, btn_release}, {52'd0, e.level, e.press, e.rel});
         if (k + 1 == switchAt) btn_raw = rawSecond;
         k++;
      end
   endtask

   task automatic pushEdge(input logic [NB-1:0] mask, input logic rising, input int n);
      btnExp_t e;
      for (int k = 0; k < n; k++) begin
         e.level = ((k >= DC + 1) == rising) ? mask : '0;
         e.press = (rising && k == DC + 1) ? mask : '0;
         e.rel   = (!rising && k == DC + 1) ? mask : '0;
         btnQ.push_back(e);
      end
   endtask

   initial begin
      vgaTab[0] = '{2'd0, 2'd3, 2'd1, 1'b1, 1'b0, 8'h01, 4'h0, 4'hF, 4'h4};
      vgaTab[1] = '{2'd1, 2'd2, 2'd0, 1'b0, 1'b1, 8'h80, 4'h4, 4'h8, 4'h0};
      vgaTab[2] = '{2'd2, 2'd1, 2'd3, 1'b1, 1'b1, 8'h5A, 4'h8, 4'h4, 4'hF};
      vgaTab[3] = '{2'd3, 2'd0, 2'd2, 1'b0, 1'b0, 8'hFF, 4'hF, 4'h0, 4'h8};
      vgaTab[4] = '{2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h00, 4'h0, 4'h0, 4'h0};
      vgaTab[5] = '{2'd3, 2'd3, 2'd3, 1'b0, 1'b1, 8'hC3, 4'hF, 4'hF, 4'hF};

      // Reset with non-idle inputs so the reset values are distinguishable.
      reset = 1'b1; btn_raw = '0;
      red_in = 2'd3; green_in = 2'd2; blue_in = 2'd1;
      hsync_in = 1'b0; vsync_in = 1'b0; led_in = 8'hA5;
      repeat (5) @(negedge clock);
      checkOutput("reset btn", {52'd0, btn_level, btn_press, btn_release}, 64'd0);
      checkOutput("reset rst_n_out", {63'd0, rst_n_out}, 64'd0);
      checkOutput("reset vga", {42'd0, red_out, green_out, blue_out, hsync_out, vsync_out, led_out},
                  {42'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h00});
      reset = 1'b0;
      @(negedge clock);
      checkOutput("rst_n_out edge1", {63'd0, rst_n_out}, 64'd0);
      checkOutput("vga first edge", {42'd0, red_out, green_out, blue_out, hsync_out, vsync_out, led_out},
                  {42'd0, 4'hF, 4'h8, 4'h4, 1'b0, 1'b0, 8'hA5});
      @(negedge clock);
      checkOutput("rst_n_out edge2", {63'd0, rst_n_out}, 64'd1);

      // VGA/LED pipeline through a scoreboard queue.
      for (int i = 0; i <= 6; i++) begin
         if (vgaQ.size() > 0)
            checkOutput($sformatf("vga vec%0d", i - 1),
                        {42'd0, red_out, green_out, blue_out, hsync_out, vsync_out, led_out},
                        {42'd0, vgaQ.pop_front()});
         if (i < 6) begin
            red_in = vgaTab[i].r; green_in = vgaTab[i].g; blue_in = vgaTab[i].b;
            hsync_in = vgaTab[i].hs; vsync_in = vgaTab[i].vs; led_in = vgaTab[i].led;
            vgaQ.push_back({vgaTab[i].er, vgaTab[i].eg, vgaTab[i].eb,
                            vgaTab[i].hs, vgaTab[i].vs, vgaTab[i].led});
         end
         @(negedge clock);
      end

      $display("[TB] single press/release on button 0");
      pushEdge(4'b0001, 1'b1, 8);
      applyStimulus("btn0 press", 4'b0001, 4'b0001, -1);
      pushEdge(4'b0001, 1'b0, 8);
      applyStimulus("btn0 release", 4'b0000, 4'b0000, -1);

      $display("[TB] 3-cycle glitch on button 1");
      for (int k = 0; k < 10; k++) btnQ.push_back('{4'b0000, 4'b0000, 4'b0000});
      applyStimulus("btn1 glitch", 4'b0010, 4'b0000, 3);

      $display("[TB] simultaneous buttons 0 and 3");
      pushEdge(4'b1001, 1'b1, 8);
      applyStimulus("btn03 press", 4'b1001, 4'b1001, -1);
      pushEdge(4'b1001, 1'b0, 8);
      applyStimulus("btn03 release", 4'b0000, 4'b0000, -1);

      $display("[TB] long hold on button 2");
      for (int k = 0; k < 34; k++) begin
         btnExp_t e;
         logic p;
         p = (k == DC + 1);
`ifdef BOARD_IO_AUTOREPEAT_EN
         if (k >= DC + 1 + RD && k < 20 + DC + 1 && ((k - (DC + 1 + RD)) % RP) == 0) p = 1'b1;
`endif
         e.level = (k >= DC + 1 && k < 20 + DC + 1) ? 4'b0100 : 4'b0000;
         e.press = p ? 4'b0100 : 4'b0000;
         e.rel   = (k == 20 + DC + 1) ? 4'b0100 : 4'b0000;
         btnQ.push_back(e);
      end
      applyStimulus("btn2 hold", 4'b0100, 4'b0000, 20);

      $display("[TB] reset in mid-operation");
      pushEdge(4'b0001, 1'b1, 7);
      applyStimulus("btn0 pre-reset", 4'b0001, 4'b0001, -1);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checkOutput("midreset btn", {52'd0, btn_level, btn_press, btn_release}, 64'd0);
      checkOutput("midreset rst_n_out", {63'd0, rst_n_out}, 64'd0);
      checkOutput("midreset vga", {42'd0, red_out, green_out, blue_out, hsync_out, vsync_out, led_out},
                  {42'd0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h00});
      btn_raw = '0;
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) btnQ.push_back('{4'b0000, 4'b0000, 4'b0000});
      applyStimulus("post-reset idle", 4'b0000, 4'b0000, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
